// File: rtl/pwm_decoder.sv
// pwm_decoder: measures one PWM line against the shared ultrasound TIME counter
// and recovers the DUTY/PHASE codes once per period. The window summary is
// latched at TIME=CYCLE-1, decoded the next cycle, and the result is registered
// so that VALID/ERR are visible while TIME=1 is on the bus.
module pwm_decoder #(
  parameter int CYCLE  = 512,
  parameter int TIME_W = $clog2(CYCLE)
) (
  input  logic              SYS_CLK,
  input  logic              RST_N,
  input  logic [TIME_W-1:0] TIME,
  input  logic              PWM_IN,
  input  logic              DUTY_OFFSET,
  output logic              VALID,
  output logic              ERR,
  output logic [TIME_W:0]   WIDTH,
  output logic [TIME_W-1:0] RISE,
  output logic [7:0]        DUTY,
  output logic [7:0]        PHASE
);

  localparam logic [TIME_W-1:0] T_LAST = TIME_W'(CYCLE - 1);
  localparam logic [TIME_W:0]   CYC_W  = (TIME_W + 1)'(CYCLE);

  // window accumulation
  logic              pwm_q, pwm_d;
  logic [TIME_W-1:0] prev_time_q, prev_time_d;
  logic              prev_ok_q, prev_ok_d;
  logic              armed_q, armed_d;
  logic [1:0]        rcnt_q, rcnt_d, fcnt_q, fcnt_d;
  logic [TIME_W-1:0] r_q, r_d, f_q, f_d;
  logic              level_q, level_d;
  logic              bad_q, bad_d;
  // window summary (stage 1)
  logic              s_go_q, s_go_d;
  logic [1:0]        s_rcnt_q, s_rcnt_d, s_fcnt_q, s_fcnt_d;
  logic [TIME_W-1:0] s_r_q, s_r_d, s_f_q, s_f_d;
  logic              s_level_q, s_level_d;
  logic              s_bad_q, s_bad_d;
  // registered results (stage 2)
  logic              valid_q, valid_d, err_q, err_d;
  logic [TIME_W:0]   width_q, width_d;
  logic [TIME_W-1:0] rise_q, rise_d;
  logic [7:0]        duty_q, duty_d, phase_q, phase_d;

  // combinational helpers
  logic              rise_e, fall_e, win_start, win_end, jump;
  logic [TIME_W-1:0] exp_time, w, dd;
  logic [TIME_W:0]   wx, cx;
  logic [7:0]        dc, pc;

  // Next-state: edge detect, per-window counters, summary latch and decode.
  always_comb begin
    rise_e    = PWM_IN & ~pwm_q;
    fall_e    = ~PWM_IN & pwm_q;
    win_start = (TIME == '0);
    win_end   = (TIME == T_LAST);
    exp_time  = (prev_time_q == T_LAST) ? '0 : prev_time_q + 1'b1;
    jump      = prev_ok_q && (TIME != exp_time);

    pwm_d       = PWM_IN;
    prev_time_d = TIME;
    prev_ok_d   = 1'b1;
    armed_d     = armed_q | win_start;

    // A TIME=0 cycle opens a fresh window; its own edges count toward it.
    rcnt_d  = win_start ? 2'd0 : rcnt_q;
    fcnt_d  = win_start ? 2'd0 : fcnt_q;
    r_d     = r_q;
    f_d     = f_q;
    level_d = win_start ? PWM_IN : level_q;
    bad_d   = (win_start ? 1'b0 : bad_q) | jump;
    if (rise_e) begin
      if (rcnt_d == 2'd0) r_d = TIME;
      if (rcnt_d != 2'd3) rcnt_d = rcnt_d + 2'd1;
    end
    if (fall_e) begin
      if (fcnt_d == 2'd0) f_d = TIME;
      if (fcnt_d != 2'd3) fcnt_d = fcnt_d + 2'd1;
    end

    // Stage 1: freeze the finished window, then clear for the next one.
    s_go_d    = win_end & armed_q;
    s_rcnt_d  = s_rcnt_q;
    s_fcnt_d  = s_fcnt_q;
    s_r_d     = s_r_q;
    s_f_d     = s_f_q;
    s_level_d = s_level_q;
    s_bad_d   = s_bad_q;
    if (win_end) begin
      s_rcnt_d  = rcnt_d;
      s_fcnt_d  = fcnt_d;
      s_r_d     = r_d;
      s_f_d     = f_d;
      s_level_d = level_d;
      s_bad_d   = bad_d;
      rcnt_d    = 2'd0;
      fcnt_d    = 2'd0;
      bad_d     = 1'b0;
    end

    // Stage 2: width wraps modulo CYCLE so a pulse straddling TIME=0 still decodes.
    wx = {1'b0, s_f_q} - {1'b0, s_r_q};
    if (s_f_q < s_r_q) wx = wx + CYC_W;
    w  = wx[TIME_W-1:0];
    dd = '0;
    if (w < TIME_W'(DUTY_OFFSET)) dc = 8'd0;
    else begin
      dd = (w - TIME_W'(DUTY_OFFSET)) >> 1;
      dc = (dd > TIME_W'(255)) ? 8'hFF : dd[7:0];
    end
    cx = {1'b0, s_r_q} + {2'b0, w[TIME_W-1:1]};
    if (cx >= CYC_W) cx = cx - CYC_W;
    pc = 8'(cx[TIME_W-1:1]);

    valid_d = 1'b0;
    err_d   = 1'b0;
    width_d = width_q;
    rise_d  = rise_q;
    duty_d  = duty_q;
    phase_d = phase_q;
    if (s_go_q) begin
      if (s_bad_q) begin
        err_d = 1'b1;
      end else if (s_rcnt_q == 2'd0 && s_fcnt_q == 2'd0) begin
        valid_d = 1'b1;
        rise_d  = '0;
        phase_d = 8'd0;
        width_d = s_level_q ? CYC_W : '0;
        duty_d  = s_level_q ? 8'hFF : 8'd0;
      end else if (s_rcnt_q == 2'd1 && s_fcnt_q == 2'd1) begin
        valid_d = 1'b1;
        width_d = {1'b0, w};
        rise_d  = s_r_q;
        duty_d  = dc;
        phase_d = pc;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset clears every window and result register at once.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_q       <= 1'b0;
      prev_time_q <= '0;
      prev_ok_q   <= 1'b0;
      armed_q     <= 1'b0;
      rcnt_q      <= 2'd0;
      fcnt_q      <= 2'd0;
      r_q         <= '0;
      f_q         <= '0;
      level_q     <= 1'b0;
      bad_q       <= 1'b0;
      s_go_q      <= 1'b0;
      s_rcnt_q    <= 2'd0;
      s_fcnt_q    <= 2'd0;
      s_r_q       <= '0;
      s_f_q       <= '0;
      s_level_q   <= 1'b0;
      s_bad_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      width_q     <= '0;
      rise_q      <= '0;
      duty_q      <= 8'd0;
      phase_q     <= 8'd0;
    end else begin
      pwm_q       <= pwm_d;
      prev_time_q <= prev_time_d;
      prev_ok_q   <= prev_ok_d;
      armed_q     <= armed_d;
      rcnt_q      <= rcnt_d;
      fcnt_q      <= fcnt_d;
      r_q         <= r_d;
      f_q         <= f_d;
      level_q     <= level_d;
      bad_q       <= bad_d;
      s_go_q      <= s_go_d;
      s_rcnt_q    <= s_rcnt_d;
      s_fcnt_q    <= s_fcnt_d;
      s_r_q       <= s_r_d;
      s_f_q       <= s_f_d;
      s_level_q   <= s_level_d;
      s_bad_q     <= s_bad_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      width_q     <= width_d;
      rise_q      <= rise_d;
      duty_q      <= duty_d;
      phase_q     <= phase_d;
    end
  end

  assign VALID = valid_q;
  assign ERR   = err_q;
  assign WIDTH = width_q;
  assign RISE  = rise_q;
  assign DUTY  = duty_q;
  assign PHASE = phase_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: drives TIME/PWM_IN window by window and
// checks the result strobed at TIME=0 of the following window.
module tb_pwm_decoder;
  localparam int CYCLE = 512;

  logic       SYS_CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [8:0] TIME = '0;
  logic       PWM_IN = 1'b0;
  logic       DUTY_OFFSET = 1'b0;
  logic       VALID, ERR;
  logic [9:0] WIDTH;
  logic [8:0] RISE;
  logic [7:0] DUTY, PHASE;

  int checks = 0;
  int errors = 0;
  logic [31:0] sv, se, sw, sr, sd, sp;
  int   extra;
  logic rst_zero;

  always #5 SYS_CLK = ~SYS_CLK;

  pwm_decoder #(.CYCLE(512), .TIME_W(9)) dut (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N), .TIME(TIME), .PWM_IN(PWM_IN),
    .DUTY_OFFSET(DUTY_OFFSET), .VALID(VALID), .ERR(ERR), .WIDTH(WIDTH),
    .RISE(RISE), .DUTY(DUTY), .PHASE(PHASE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0 low, 1 high, 2 single pulse [r,f) modulo CYCLE, 3 two pulses
  function automatic logic lvl(input int mode, input int r, input int f, input int t);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return (r < f) ? (t >= r && t < f) : (t >= r || t < f);
      default: return (t >= 10 && t < 50) || (t >= 300 && t < 340);
    endcase
  endfunction

  task automatic tick(input int t, input logic p);
    TIME = 9'(t);
    PWM_IN = p;
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic snap();
    sv = 32'(VALID); se = 32'(ERR); sw = 32'(WIDTH);
    sr = 32'(RISE);  sd = 32'(DUTY); sp = 32'(PHASE);
  endtask

  // ra: TIME at which reset is pulsed for 3 cycles; jf->jt: TIME jump
  task automatic run_window(input int start, input int mode, input int r, input int f,
                            input int jf, input int jt, input int ra);
    int t;
    t = start;
    extra = 0;
    rst_zero = 1'b1;
    while (t < CYCLE) begin
      if (t == ra) begin
        RST_N = 1'b0;
        #1;
        rst_zero = (VALID === 1'b0 && ERR === 1'b0 && WIDTH === '0 && RISE === '0 &&
                    DUTY === '0 && PHASE === '0);
      end
      if (ra >= 0 && t == ra + 3) RST_N = 1'b1;
      tick(t, lvl(mode, r, f, t));
      if (t == 0) snap();
      else if (VALID !== 1'b0 || ERR !== 1'b0) extra++;
      if (t == jf) t = jt;
      else t++;
    end
  endtask

  task automatic res(input string tag, input int v, input int e, input int w,
                     input int r, input int d, input int p);
    chk({tag, " valid"}, sv, 32'(v));
    chk({tag, " err"},   se, 32'(e));
    chk({tag, " width"}, sw, 32'(w));
    chk({tag, " rise"},  sr, 32'(r));
    chk({tag, " duty"},  sd, 32'(d));
    chk({tag, " phase"}, sp, 32'(p));
    chk({tag, " extra_strobes"}, 32'(extra), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    tick(0, 1'b0);
    tick(1, 1'b0);
    snap();
    extra = 0;
    res("reset", 0, 0, 0, 0, 0, 0);

    // partial window after reset release is discarded silently
    RST_N = 1'b1;
    run_window(400, 0, 0, 0, -1, -1, -1);
    chk("partial strobes", 32'(extra), 32'd0);

    DUTY_OFFSET = 1'b1;
    run_window(0, 2, 100, 201, -1, -1, -1);
    chk("first_full valid", sv, 32'd0);
    chk("first_full err", se, 32'd0);
    chk("first_full extra_strobes", 32'(extra), 32'd0);

    run_window(0, 3, 0, 0, -1, -1, -1);
    res("pulse_100_201", 1, 0, 101, 100, 50, 75);

    run_window(0, 2, 450, 139, -1, -1, -1);
    res("two_pulses", 0, 1, 101, 100, 50, 75);

    // previous window ended low, so this one also sees a rise at TIME=0
    run_window(0, 2, 450, 139, -1, -1, -1);
    res("wrap_entry", 0, 1, 101, 100, 50, 75);

    run_window(0, 1, 0, 0, -1, -1, -1);
    res("wrap", 1, 0, 201, 450, 100, 19);

    run_window(0, 0, 0, 0, -1, -1, -1);
    res("held_high", 1, 0, 512, 0, 255, 0);

    // this window saw a single fall at TIME=0
    run_window(0, 0, 0, 0, -1, -1, -1);
    res("fall_only", 0, 1, 512, 0, 255, 0);

    DUTY_OFFSET = 1'b0;
    run_window(0, 2, 100, 201, 200, 205, -1);
    res("held_low", 1, 0, 0, 0, 0, 0);

    run_window(0, 2, 100, 201, -1, -1, -1);
    res("time_jump", 0, 1, 0, 0, 0, 0);

    run_window(0, 2, 30, 60, -1, -1, 250);
    res("clean_offset0", 1, 0, 101, 100, 50, 75);
    chk("reset_mid outputs_zero", 32'(rst_zero), 32'd1);

    DUTY_OFFSET = 1'b1;
    run_window(0, 2, 20, 121, -1, -1, -1);
    chk("post_reset valid", sv, 32'd0);
    chk("post_reset err", se, 32'd0);
    chk("post_reset extra_strobes", 32'(extra), 32'd0);

    run_window(0, 0, 0, 0, -1, -1, -1);
    res("first_after_reset", 1, 0, 101, 20, 50, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
